mem_request_unit: RTL and testbench
===================================

// Module: mem_request_unit
// PURPOSE
//  Parametrised successor to the single-cycle request unit.
//  Sequences I-fetch and D-access requests between the datapath and the cache/memory
//  controller, and stalls the PC until each access completes.
//  Adds load-linked/store-conditional (LL/SC) link tracking with snoop invalidation,
//  a data-wait timeout watchdog and a sticky halt mode for multicore builds.
//  Sits between datapath control and the icache/dcache ports, one instance per core.
// PARAMETERS
//  ADDR_W   32   width of data address, link register and snoop address
//  WAIT_W   8    width of data-wait counter
//  MAX_WAIT 255  DWAIT cycles without dhit before timeout (must be < 2**WAIT_W)
// PORTS
//  CLK        in   1       rising-edge clock
//  RST        in   1       synchronous, active-high reset
//  regwr      in   1       current instruction writes the register file
//  dcuREN     in   1       current instruction is a load
//  dcuWEN     in   1       current instruction is a store
//  dcuLL      in   1       load is LL (valid only with dcuREN)
//  dcuSC      in   1       store is SC (valid only with dcuWEN)
//  daddr      in   ADDR_W  data address of current instruction
//  halt       in   1       halt instruction decoded
//  ihit       in   1       instruction fetch complete
//  dhit       in   1       data access complete
//  snoopvalid in   1       remote core invalidates snoopaddr
//  snoopaddr  in   ADDR_W  snooped word address
//  imemREN    out  1       instruction read request
//  dmemREN    out  1       data read request
//  dmemWEN    out  1       data write request
//  pcEN       out  1       advance PC / retire instruction
//  wreq       out  1       register-file write enable (regwr & pcEN)
//  scok       out  1       SC result bit, valid when pcEN on an SC
//  timeout    out  1       sticky watchdog error
//  halted     out  1       sticky halt indication
// BEHAVIOUR
//  - Reset: state IDLE, link invalid, counter 0. While RST=1 all outputs are 0.
//  - States:
//    IDLE: imemREN=1.
//      ihit & halt                       -> HALTED.
//      ihit & (dcuREN|dcuWEN), SC passes -> DWAIT next cycle.
//      ihit, no data access              -> pcEN=1 same cycle (combinational).
//    DWAIT: imemREN=0; dmemREN/dmemWEN registered from the latched op; counter +1/cycle.
//      dhit                -> pcEN=1 same cycle; next state IDLE; counter cleared.
//      counter==MAX_WAIT   -> ERR.
//    ERR: timeout=1; all requests and pcEN 0 until RST.
//    HALTED: halted=1; all requests 0 until RST.
//  - Halt is taken only from IDLE, so an in-flight data access always completes first.
//  - pcEN is never 1 in two different states in the same cycle.
//  - wreq = regwr & pcEN. scok = 0 except when a successful SC retires.
//  - LL/SC:
//    LL retiring (dhit) sets linkvalid=1 and linkaddr=daddr.
//    SC with linkvalid & linkaddr==daddr: normal store via DWAIT; scok=1 at dhit;
//      link cleared.
//    SC that fails: no DWAIT, dmemWEN never asserted; pcEN=1 on ihit with scok=0.
//    Own non-SC store retiring to linkaddr clears the link.
//    snoopvalid & snoopaddr==linkaddr clears the link.
//    Snoop and SC evaluation in the same cycle: snoop wins and the SC fails.
//    Snoop arriving while the SC is already in DWAIT is ignored; the SC succeeds.
//    LL retiring in the same cycle as a matching snoop: the set wins (new link).
//  - Counter saturates at MAX_WAIT. No wrap is possible because ERR is entered first.
// STRUCTURE
//  - cpu_types_pkg: typedef enum logic [1:0] {IDLE, DWAIT, ERR, HALTED} req_state_t.
//  - Sub-module ll_link_reg: linkvalid/linkaddr register with set, clear and
//    snoop-compare logic.
//    Ports: CLK, RST, set, setaddr, clr, cmpaddr, snoopvalid, snoopaddr, match.
// TESTING
//  1 RST 2 cycles, then ihit=1, no data op -> pcEN=1, wreq=regwr, imemREN=1 every cycle.
//  2 ihit with dcuREN, dhit after 3 cycles -> dmemREN=1 for 3 cycles; pcEN=1 only in
//    the dhit cycle.
//  3 LL to 0x100, then SC to 0x100 -> dmemWEN asserted; scok=1 at dhit.
//  4 LL to 0x100, snoop 0x100, then SC to 0x100 -> no dmemWEN; pcEN=1 with scok=0.
//  5 SC evaluated in the same cycle as a matching snoop -> SC fails.
//    SC to 0x104 after LL to 0x100 -> SC fails.
//  6 dcuWEN, dhit never arrives, MAX_WAIT=4 -> timeout=1 after 4 DWAIT cycles;
//    outputs 0 until RST.
//  7 halt during DWAIT -> data op completes, then halted=1 and imemREN=0.
//    Mid-DWAIT RST -> all outputs 0 next cycle; link invalid.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the per-core request sequencer.
package cpu_types_pkg;

  typedef enum logic [1:0] {IDLE, DWAIT, ERR, HALTED} req_state_t;

endpackage

// File: rtl/ll_link_reg.sv
// Load-linked reservation: one valid bit plus address, killed by own stores or remote snoops.
module ll_link_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              set,
  input  logic [ADDR_W-1:0] setaddr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] cmpaddr,
  input  logic              snoopvalid,
  input  logic [ADDR_W-1:0] snoopaddr,
  output logic              match
);

  logic              linkvalid;
  logic [ADDR_W-1:0] linkaddr;
  logic              snoop_hit;

  assign snoop_hit = snoopvalid & linkvalid & (snoopaddr == linkaddr);
  // A snoop landing in the same cycle as the compare already kills the reservation.
  assign match     = linkvalid & (cmpaddr == linkaddr) & ~snoop_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      linkvalid <= 1'b0;
    end else if (set) begin
      linkvalid <= 1'b1;
    end else if (clr | snoop_hit) begin
      linkvalid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (set) begin
      linkaddr <= setaddr;
    end
  end

endmodule

// File: rtl/mem_request_unit.sv
// Sequences I-fetch and D-access requests, stalls the PC until each access retires,
// and tracks LL/SC reservations, a data-wait watchdog and a sticky halt.
module mem_request_unit
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              regwr,
  input  logic              dcuREN,
  input  logic              dcuWEN,
  input  logic              dcuLL,
  input  logic              dcuSC,
  input  logic [ADDR_W-1:0] daddr,
  input  logic              halt,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              snoopvalid,
  input  logic [ADDR_W-1:0] snoopaddr,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              pcEN,
  output logic              wreq,
  output logic              scok,
  output logic              timeout,
  output logic              halted
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  req_state_t        state;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] op_addr;
  logic              op_ren;
  logic              op_wen;
  logic              op_ll;
  logic              op_sc;
  logic              imem_q;
  logic              timeout_q;
  logic              halted_q;

  logic              in_idle;
  logic              in_dwait;
  logic              link_match;
  logic              go;
  logic              retire;
  logic              pc_en;

  assign in_idle  = (state == IDLE);
  assign in_dwait = (state == DWAIT);
  assign cnt_inc  = cnt + WAIT_W'(1);
  assign retire   = in_dwait & dhit;

  // A failing SC never reaches DWAIT: it retires on the fetch with scok=0.
  assign go = dcuREN | (dcuWEN & ~(dcuSC & ~link_match));

  ll_link_reg #(.ADDR_W(ADDR_W)) u_link (
    .CLK        (CLK),
    .RST        (RST),
    .set        (retire & op_ll),
    .setaddr    (op_addr),
    .clr        (retire & op_wen & (op_sc | link_match)),
    .cmpaddr    (in_dwait ? op_addr : daddr),
    .snoopvalid (snoopvalid),
    .snoopaddr  (snoopaddr),
    .match      (link_match)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      op_ren    <= 1'b0;
      op_wen    <= 1'b0;
      op_ll     <= 1'b0;
      op_sc     <= 1'b0;
      imem_q    <= 1'b1;
      timeout_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ihit & halt) begin
            state    <= HALTED;
            imem_q   <= 1'b0;
            halted_q <= 1'b1;
          end else if (ihit & go) begin
            state   <= DWAIT;
            imem_q  <= 1'b0;
            cnt     <= '0;
            op_addr <= daddr;
            op_ren  <= dcuREN;
            op_wen  <= dcuWEN;
            op_ll   <= dcuREN & dcuLL;
            op_sc   <= dcuWEN & dcuSC;
          end
        end
        DWAIT: begin
          if (dhit) begin
            state  <= IDLE;
            imem_q <= 1'b1;
            cnt    <= '0;
            op_ren <= 1'b0;
            op_wen <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == MAX_CNT) begin
              state     <= ERR;
              timeout_q <= 1'b1;
              op_ren    <= 1'b0;
              op_wen    <= 1'b0;
            end
          end
        end
        ERR: ;
        HALTED: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign pc_en = ~RST & ((in_idle & ihit & ~halt & ~go) | retire);

  assign imemREN = ~RST & imem_q;
  assign dmemREN = ~RST & op_ren;
  assign dmemWEN = ~RST & op_wen;
  assign pcEN    = pc_en;
  assign wreq    = regwr & pc_en;
  assign scok    = ~RST & retire & op_sc;
  assign timeout = ~RST & timeout_q;
  assign halted  = ~RST & halted_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit: directed LL/SC, watchdog, halt and reset scenarios
// plus randomized instruction streams against an instruction-level link model.
module tb_mem_request_unit;

  localparam int AW = 32;
  localparam int WW = 8;
  localparam int MW = 4;

  localparam int K_NOP = 0;
  localparam int K_LD  = 1;
  localparam int K_LL  = 2;
  localparam int K_ST  = 3;
  localparam int K_SC  = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          regwr = 1'b0, dcuREN = 1'b0, dcuWEN = 1'b0, dcuLL = 1'b0, dcuSC = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic          halt = 1'b0, ihit = 1'b0, dhit = 1'b0, snoopvalid = 1'b0;
  logic [AW-1:0] snoopaddr = '0;
  logic          imemREN, dmemREN, dmemWEN, pcEN, wreq, scok, timeout, halted;

  logic [7:0]    obs;
  int            checks = 0;
  int            errors = 0;

  // Reference reservation state, tracked per retired instruction.
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr = '0;

  mem_request_unit #(.ADDR_W(AW), .WAIT_W(WW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST), .regwr(regwr), .dcuREN(dcuREN), .dcuWEN(dcuWEN),
    .dcuLL(dcuLL), .dcuSC(dcuSC), .daddr(daddr), .halt(halt), .ihit(ihit),
    .dhit(dhit), .snoopvalid(snoopvalid), .snoopaddr(snoopaddr),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .pcEN(pcEN),
    .wreq(wreq), .scok(scok), .timeout(timeout), .halted(halted)
  );

  always #5 CLK = ~CLK;

  assign obs = {imemREN, dmemREN, dmemWEN, pcEN, wreq, scok, timeout, halted};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 2))
      0:       return 32'h100;
      1:       return 32'h104;
      default: return 32'h200;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    regwr = 0; dcuREN = 0; dcuWEN = 0; dcuLL = 0; dcuSC = 0; daddr = '0;
    halt = 0; ihit = 0; dhit = 0; snoopvalid = 0; snoopaddr = '0;
  endtask

  task automatic test_reset(input int n);
    RST = 1;
    for (int i = 0; i < n; i++) begin
      ihit = 1; dhit = rbit(); regwr = 1; dcuREN = rbit(); halt = rbit();
      @(negedge CLK);
      checks++;
      if (obs !== 8'b0000_0000) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %b want %b", i, obs, 8'b0000_0000);
      end
      tick();
    end
    RST = 0;
    m_valid = 0;
    clear_inputs();
    @(negedge CLK);
    checks++;
    if (obs !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", obs, 8'b1000_0000);
    end
    tick();
  endtask

  task automatic test_fetch_only();
    logic       rw;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      rw = rbit();
      ihit = (i != 5); regwr = rw;
      exp = (i != 5) ? {4'b1001, rw, 3'b000} : 8'b1000_0000;
      @(negedge CLK);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL fetch_only cyc%0d: got %b want %b", i, obs, exp);
      end
      tick();
    end
    clear_inputs();
  endtask

  // One instruction from fetch to retirement; expectations come from the link model.
  task automatic exec_instr(input int kind, input logic [AW-1:0] addr, input int lat,
                            input logic rw, input logic fsnp, input logic [AW-1:0] fsaddr,
                            input int dsnp_k, input logic [AW-1:0] dsaddr,
                            input logic rnd, input string name);
    logic       go, last, snp, ld, st, sc;
    logic [AW-1:0] sa;
    logic [7:0] exp;
    ld = (kind == K_LD) || (kind == K_LL);
    st = (kind == K_ST) || (kind == K_SC);
    sc = (kind == K_SC);
    ihit = 1; dhit = 0; halt = 0; regwr = rw; daddr = addr;
    dcuREN = ld; dcuLL = (kind == K_LL); dcuWEN = st; dcuSC = sc;
    snoopvalid = fsnp; snoopaddr = fsaddr;
    go = (kind != K_NOP) &&
         !(sc && !(m_valid && m_addr == addr && !(fsnp && fsaddr == m_addr)));
    exp = {3'b100, !go, rw & !go, 3'b000};
    @(negedge CLK);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s fetch: got %b want %b", name, obs, exp);
    end
    if (fsnp && fsaddr == m_addr) m_valid = 0;
    tick();
    if (go) begin
      for (int k = 1; k <= lat; k++) begin
        last = (k == lat);
        ihit = rbit(); dhit = last;
        if (rnd) begin
          snp = ($urandom_range(0, 2) == 0);
          sa  = pick_addr();
        end else begin
          snp = (k == dsnp_k);
          sa  = dsaddr;
        end
        snoopvalid = snp; snoopaddr = sa;
        exp = {1'b0, ld, st, last, rw & last, sc & last, 2'b00};
        @(negedge CLK);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL %s dwait k=%0d: got %b want %b", name, k, obs, exp);
        end
        if (snp && sa == m_addr) m_valid = 0;
        if (last) begin
          if (st && addr == m_addr) m_valid = 0;
          if (kind == K_LL) begin
            m_valid = 1;
            m_addr  = addr;
          end
        end
        tick();
      end
    end
    clear_inputs();
  endtask

  task automatic test_ll_sc();
    exec_instr(K_LD, 32'h80, 3, 1, 0, '0, 0, '0, 0, "load_lat3");
    exec_instr(K_LL, 32'h100, 2, 1, 0, '0, 0, '0, 0, "ll_100");
    exec_instr(K_SC, 32'h100, 2, 1, 0, '0, 0, '0, 0, "sc_100_pass");
    exec_instr(K_SC, 32'h100, 1, 1, 0, '0, 0, '0, 0, "sc_after_sc_fail");
  endtask

  task automatic test_snoop_kill();
    exec_instr(K_LL, 32'h100, 1, 1, 0, '0, 0, '0, 0, "ll_100_b");
    exec_instr(K_NOP, 32'h0, 0, 0, 1, 32'h100, 0, '0, 0, "nop_snoop");
    exec_instr(K_SC, 32'h100, 1, 1, 0, '0, 0, '0, 0, "sc_after_snoop");
    exec_instr(K_LL, 32'h100, 1, 1, 0, '0, 0, '0, 0, "ll_100_c");
    exec_instr(K_SC, 32'h100, 1, 1, 1, 32'h100, 0, '0, 0, "sc_same_cycle_snoop");
    exec_instr(K_LL, 32'h100, 1, 1, 0, '0, 0, '0, 0, "ll_100_d");
    exec_instr(K_SC, 32'h104, 1, 1, 0, '0, 0, '0, 0, "sc_wrong_addr");
  endtask

  task automatic test_link_corners();
    exec_instr(K_LL, 32'h100, 1, 1, 0, '0, 0, '0, 0, "ll_100_e");
    exec_instr(K_SC, 32'h100, 3, 1, 0, '0, 2, 32'h100, 0, "sc_dwait_snoop");
    exec_instr(K_LL, 32'h100, 2, 1, 0, '0, 2, 32'h100, 0, "ll_set_wins");
    exec_instr(K_SC, 32'h100, 1, 0, 0, '0, 0, '0, 0, "sc_after_set_wins");
    exec_instr(K_LL, 32'h200, 1, 1, 0, '0, 0, '0, 0, "ll_200");
    exec_instr(K_ST, 32'h200, 2, 0, 0, '0, 0, '0, 0, "own_store");
    exec_instr(K_SC, 32'h200, 1, 0, 0, '0, 0, '0, 0, "sc_after_store");
    exec_instr(K_LD, 32'h300, MW, 1, 0, '0, 0, '0, 0, "load_max_wait");
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    ihit = 1; dcuWEN = 1; daddr = 32'h300;
    @(negedge CLK);
    checks++;
    if (obs !== 8'b1000_0000) begin
      errors++;
      $display("FAIL timeout_fetch: got %b want %b", obs, 8'b1000_0000);
    end
    tick();
    for (int k = 1; k <= MW + 3; k++) begin
      ihit = rbit();
      dhit = (k > MW) ? rbit() : 1'b0;
      exp = (k <= MW) ? 8'b0010_0000 : 8'b0000_0010;
      @(negedge CLK);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout k=%0d: got %b want %b", k, obs, exp);
      end
      tick();
    end
    clear_inputs();
    test_reset(2);
  endtask

  task automatic test_halt();
    logic [7:0] exp [6] = '{8'b1000_0000, 8'b1000_0000, 8'b0100_0000,
                            8'b0101_1000, 8'b1000_0000, 8'b0000_0001};
    for (int c = 0; c < 8; c++) begin
      regwr = 1;
      case (c)
        0: begin ihit = 0; halt = 1; end
        1: begin ihit = 1; halt = 0; dcuREN = 1; daddr = 32'h200; end
        2: begin ihit = 1; halt = 1; dhit = 0; end
        3: begin ihit = 1; halt = 1; dhit = 1; end
        4: begin ihit = 1; halt = 1; dhit = 0; dcuREN = 0; end
        default: begin ihit = rbit(); halt = rbit(); dhit = rbit(); end
      endcase
      @(negedge CLK);
      checks++;
      if (obs !== exp[(c < 5) ? c : 5]) begin
        errors++;
        $display("FAIL halt cyc%0d: got %b want %b", c, obs, exp[(c < 5) ? c : 5]);
      end
      tick();
    end
    clear_inputs();
    test_reset(1);
  endtask

  task automatic test_mid_dwait_reset();
    logic [7:0] exp [4] = '{8'b1000_0000, 8'b0100_0000, 8'b0000_0000, 8'b1000_0000};
    exec_instr(K_LL, 32'h100, 1, 1, 0, '0, 0, '0, 0, "ll_before_rst");
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin ihit = 1; dcuREN = 1; daddr = 32'h200; end
        1: begin ihit = 0; dhit = 0; end
        2: begin RST = 1; ihit = 1; dhit = 1; end
        default: begin RST = 0; clear_inputs(); m_valid = 0; end
      endcase
      @(negedge CLK);
      checks++;
      if (obs !== exp[c]) begin
        errors++;
        $display("FAIL mid_rst cyc%0d: got %b want %b", c, obs, exp[c]);
      end
      tick();
    end
    exec_instr(K_SC, 32'h100, 1, 1, 0, '0, 0, '0, 0, "sc_after_rst");
  endtask

  task automatic test_random(input int n);
    int         kind;
    logic       snp;
    logic [AW-1:0] sa;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        snp = rbit(); sa = pick_addr();
        snoopvalid = snp; snoopaddr = sa; dhit = rbit();
        @(negedge CLK);
        checks++;
        if (obs !== 8'b1000_0000) begin
          errors++;
          $display("FAIL rand_bubble i=%0d: got %b want %b", i, obs, 8'b1000_0000);
        end
        if (snp && sa == m_addr) m_valid = 0;
        tick();
        clear_inputs();
      end
      kind = $urandom_range(0, 4);
      exec_instr(kind, pick_addr(), $urandom_range(1, MW), rbit(),
                 ($urandom_range(0, 3) == 0), pick_addr(), 0, '0, 1, "rand");
    end
  endtask

  initial begin
    clear_inputs();
    test_reset(2);
    test_fetch_only();
    test_ll_sc();
    test_snoop_kill();
    test_link_corners();
    test_timeout();
    test_halt();
    test_mid_dwait_reset();
    test_random(150);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
